// File: rtl/nbym_seq_divider_pkg.sv
// Shared definitions for the N-by-M sequential restoring divider.
// Holds the controller state encoding and a width helper for the step counter.
package nbym_seq_divider_pkg;

  // Controller states: waiting for a request, or stepping through the bits
  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } div_state_e;

  // Bits needed to hold a step count from 0 up to and including n
  function automatic int count_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/nbym_seq_divider_if.sv
// Request/result bundle for the N-by-M sequential divider.
// The master issues soc with operands; the slave returns the registered result.
interface nbym_seq_divider_if #(
  parameter int N = 8,
  parameter int M = 4
);

  logic         soc;
  logic [N-1:0] x;
  logic [M-1:0] y;
  logic [N-1:0] q;
  logic [M-1:0] r;
  logic         eoc;
  logic         div_by_zero;

  modport master (
    output soc, x, y,
    input  q, r, eoc, div_by_zero
  );

  modport slave (
    input  soc, x, y,
    output q, r, eoc, div_by_zero
  );

endinterface

// File: rtl/nbym_seq_divider_div_step.sv
// One restoring-division step: shift a dividend bit into the partial remainder,
// try to subtract the divisor, and keep the difference only when no borrow occurs.
module div_step #(
  parameter int M = 4
) (
  input  logic [M-1:0] rem_in,
  input  logic         bit_in,
  input  logic [M-1:0] divisor,
  output logic         q_bit,
  output logic [M-1:0] rem_out
);

  logic [M:0]   shifted;
  logic [M-1:0] diff_lo;

  // Trial subtraction; the low M bits of the difference are all that survive
  // because a successful subtract always leaves a value below the divisor
  always_comb begin
    shifted = {rem_in, bit_in};
    diff_lo = shifted[M-1:0] - divisor;
    q_bit   = (shifted >= {1'b0, divisor});
    rem_out = q_bit ? diff_lo : shifted[M-1:0];
  end

endmodule

// File: rtl/nbym_seq_divider.sv
// N-by-M unsigned sequential divider, one quotient bit per clock, MSB first.
// eoc is high while idle; q/r/div_by_zero are updated only when a run completes.
module nbym_seq_divider
  import nbym_seq_divider_pkg::*;
#(
  parameter int N = 8,
  parameter int M = 4
) (
  input  logic                 clock,
  input  logic                 reset_,
  nbym_seq_divider_if.slave    bus
);

  localparam int CW = count_width(N);

  div_state_e    state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [N-1:0]  dividend_q, dividend_d;
  logic [M-1:0]  divisor_q, divisor_d;
  logic [M-1:0]  rem_q, rem_d;
  logic [N-1:0]  quot_q, quot_d;
  logic [N-1:0]  q_q, q_d;
  logic [M-1:0]  r_q, r_d;
  logic          dbz_q, dbz_d;

  logic          step_q_bit;
  logic [M-1:0]  step_rem;

  div_step #(.M(M)) u_step (
    .rem_in  (rem_q),
    .bit_in  (dividend_q[N-1]),
    .divisor (divisor_q),
    .q_bit   (step_q_bit),
    .rem_out (step_rem)
  );

  // Next-state logic: accept a request in IDLE, step once per cycle in CALC,
  // and publish the result on the final step
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    rem_d      = rem_q;
    quot_d     = quot_q;
    q_d        = q_q;
    r_d        = r_q;
    dbz_d      = dbz_q;
    case (state_q)
      IDLE: begin
        if (bus.soc) begin
          state_d    = CALC;
          dividend_d = bus.x;
          divisor_d  = bus.y;
          count_d    = CW'(N);
          rem_d      = '0;
          quot_d     = '0;
        end
      end
      CALC: begin
        dividend_d = {dividend_q[N-2:0], 1'b0};
        rem_d      = step_rem;
        quot_d     = {quot_q[N-2:0], step_q_bit};
        count_d    = count_q - CW'(1);
        if (count_q == CW'(1)) begin
          state_d = IDLE;
          q_d     = {quot_q[N-2:0], step_q_bit};
          r_d     = step_rem;
          dbz_d   = (divisor_q == '0);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any run and clears the result
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state_q    <= IDLE;
      count_q    <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      q_q        <= '0;
      r_q        <= '0;
      dbz_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      rem_q      <= rem_d;
      quot_q     <= quot_d;
      q_q        <= q_d;
      r_q        <= r_d;
      dbz_q      <= dbz_d;
    end
  end

  // Drive the result side of the bundle straight from registers
  always_comb begin
    bus.q           = q_q;
    bus.r           = r_q;
    bus.div_by_zero = dbz_q;
    bus.eoc         = (state_q == IDLE);
  end

endmodule

// File: tb/tb_nbym_seq_divider.sv
// Directed and back-to-back checks for the N-by-M sequential divider (N=8, M=4).
module tb_nbym_seq_divider;

  localparam int N = 8;
  localparam int M = 4;

  logic clock;
  logic reset_;
  int   checkCount;
  int   failCount;
  logic [N-1:0] prevQ;
  logic [M-1:0] prevR;

  nbym_seq_divider_if #(.N(N), .M(M)) bus ();

  nbym_seq_divider #(.N(N), .M(M)) dut (
    .clock  (clock),
    .reset_ (reset_),
    .bus    (bus)
  );

  // Free-running clock, 10 time units per period
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Global time limit so the bench always terminates
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts every check and reports any difference
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Launch one run from IDLE (called at a negedge), optionally pulse soc
  // mid-run with other operands, then check latency, result and idle return
  task automatic applyStimulus(input logic [N-1:0] xIn, input logic [M-1:0] yIn,
                               input logic [N-1:0] expQ, input logic [M-1:0] expR,
                               input logic expDbz, input bit midPulse);
    int lowCycles;
    bus.soc = 1'b1;
    bus.x   = xIn;
    bus.y   = yIn;
    @(negedge clock);
    bus.soc = 1'b0;
    bus.x   = ~xIn;
    bus.y   = ~yIn;
    checkOutput("eoc_low_after_soc", {31'd0, bus.eoc}, 32'd0);
    checkOutput("q_hold_in_calc", {24'd0, bus.q}, {24'd0, prevQ});
    checkOutput("r_hold_in_calc", {28'd0, bus.r}, {28'd0, prevR});
    lowCycles = 0;
    while (bus.eoc == 1'b0 && lowCycles < 20) begin
      lowCycles++;
      if (midPulse && lowCycles == 3) begin
        bus.soc = 1'b1;
        bus.x   = 8'd50;
        bus.y   = 4'd5;
      end else begin
        bus.soc = 1'b0;
      end
      @(negedge clock);
    end
    checkOutput("eoc_low_cycles", lowCycles, 32'd8);
    checkOutput("q_result", {24'd0, bus.q}, {24'd0, expQ});
    checkOutput("r_result", {28'd0, bus.r}, {28'd0, expR});
    checkOutput("div_by_zero", {31'd0, bus.div_by_zero}, {31'd0, expDbz});
    prevQ = expQ;
    prevR = expR;
    @(negedge clock);
    checkOutput("idle_stays_idle", {31'd0, bus.eoc}, 32'd1);
  endtask

  initial begin
    int lowCycles;
    logic [N-1:0] xv;
    logic [M-1:0] yv;
    logic [N-1:0] expQ;
    logic [M-1:0] expR;
    logic         expDbz;

    checkCount = 0;
    failCount  = 0;
    prevQ      = '0;
    prevR      = '0;
    bus.soc    = 1'b0;
    bus.x      = '0;
    bus.y      = '0;
    reset_     = 1'b0;
    #1;
    checkOutput("reset_eoc", {31'd0, bus.eoc}, 32'd1);
    checkOutput("reset_q", {24'd0, bus.q}, 32'd0);
    checkOutput("reset_r", {28'd0, bus.r}, 32'd0);
    checkOutput("reset_dbz", {31'd0, bus.div_by_zero}, 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset_ = 1'b1;

    // Directed vectors with hand-computed quotients and remainders
    applyStimulus(8'd200, 4'd13, 8'd15, 4'd5, 1'b0, 1'b0);
    applyStimulus(8'd7, 4'd9, 8'd0, 4'd7, 1'b0, 1'b0);
    applyStimulus(8'd255, 4'd1, 8'd255, 4'd0, 1'b0, 1'b0);
    applyStimulus(8'd255, 4'd15, 8'd17, 4'd0, 1'b0, 1'b0);
    applyStimulus(8'hA5, 4'd0, 8'hFF, 4'h5, 1'b1, 1'b0);
    applyStimulus(8'd10, 4'd3, 8'd3, 4'd1, 1'b0, 1'b0);
    applyStimulus(8'd100, 4'd7, 8'd14, 4'd2, 1'b0, 1'b1);

    // Abort a run partway through with an asynchronous reset
    bus.soc = 1'b1;
    bus.x   = 8'd100;
    bus.y   = 4'd7;
    @(negedge clock);
    bus.soc = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("calc_before_abort", {31'd0, bus.eoc}, 32'd0);
    reset_ = 1'b0;
    #1;
    checkOutput("abort_eoc", {31'd0, bus.eoc}, 32'd1);
    checkOutput("abort_q", {24'd0, bus.q}, 32'd0);
    checkOutput("abort_r", {28'd0, bus.r}, 32'd0);
    checkOutput("abort_dbz", {31'd0, bus.div_by_zero}, 32'd0);
    @(negedge clock);
    reset_ = 1'b1;
    prevQ  = '0;
    prevR  = '0;
    applyStimulus(8'd9, 4'd2, 8'd4, 4'd1, 1'b0, 1'b0);

    // Back-to-back runs with soc held high; operands scrambled during CALC
    for (int i = 0; i < 200; i++) begin
      xv = N'($urandom_range(0, 255));
      yv = M'($urandom_range(0, 15));
      if (yv == '0) begin
        expQ   = '1;
        expR   = xv[M-1:0];
        expDbz = 1'b1;
      end else begin
        expQ   = xv / {4'd0, yv};
        expR   = M'(xv % {4'd0, yv});
        expDbz = 1'b0;
      end
      bus.soc = 1'b1;
      bus.x   = xv;
      bus.y   = yv;
      @(negedge clock);
      checkOutput("b2b_single_idle_gap", {31'd0, bus.eoc}, 32'd0);
      bus.x = N'($urandom);
      bus.y = M'($urandom);
      lowCycles = 0;
      while (bus.eoc == 1'b0 && lowCycles < 20) begin
        lowCycles++;
        @(negedge clock);
      end
      checkOutput("b2b_eoc_low_cycles", lowCycles, 32'd8);
      checkOutput("b2b_q", {24'd0, bus.q}, {24'd0, expQ});
      checkOutput("b2b_r", {28'd0, bus.r}, {28'd0, expR});
      checkOutput("b2b_dbz", {31'd0, bus.div_by_zero}, {31'd0, expDbz});
    end
    bus.soc = 1'b0;
    @(negedge clock);
    checkOutput("final_idle", {31'd0, bus.eoc}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
